mod_n_up_counter: RTL and testbench
===================================

Name: mod_n_up_counter

Overview:
- Programmable modulo-N up counter; the counting-up counterpart to the existing down counters in the all-in-one counter set.
- Counts 0..MOD-1 on enabled clock edges.
- Supports free-running (wrap) and one-shot (stop at terminal) operation, synchronous parallel load and start/stop control.
- Provides a cascade carry and a saturating wrap counter so multiple instances can chain into multi-digit counters.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 5, modulus; count range 0..MOD-1. Legal: 2 <= MOD <= 2^WIDTH.
- WRAP_W, 8, width of the wrap counter.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  reset; asynchronous assert, active-low.
- en  input  1  count enable; qualifies each increment.
- start  input  1  starts counting (single-cycle pulse expected; level also tolerated).
- stop  input  1  pauses counting; value is held.
- oneshot  input  1  0 = free-run wrap, 1 = stop at MOD-1. Sampled every cycle.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load data.
- Cout  output  WIDTH  current count (registered).
- running  output  1  high in state RUN (registered).
- done  output  1  high in state DONE (registered).
- tc  output  1  combinational; Cout == MOD-1.
- carry_out  output  1  combinational; tc & en & running. Drives the next stage's en.
- wrap_cnt  output  WRAP_W  number of MOD-1 -> 0 wraps; saturates at all-ones.
- load_err  output  1  one-cycle pulse; last load_val was >= MOD.

Behaviour:
- Reset (clear=0, asynchronous):
  - Cout=0, state=IDLE, running=0, done=0, wrap_cnt=0, load_err=0.
  - Counting resumes only after a start pulse following release.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Cout held. start -> RUN.
  - RUN: each cycle with en=1, Cout += 1. At Cout==MOD-1 with en=1:
    - oneshot=0: Cout -> 0, wrap_cnt += 1 (saturating), stay in RUN.
    - oneshot=1: Cout holds MOD-1, go to DONE.
  - RUN: stop=1 -> IDLE, Cout held; no increment that cycle.
  - DONE: Cout held at MOD-1. start -> Cout=0, RUN (restart). stop -> IDLE.
- Priority per edge: clear (async) > load > stop > start > count.
- Load:
  - Takes effect on the next edge in any state. State is unchanged.
  - No increment that cycle, even with en=1.
  - load_val >= MOD: Cout=0 and load_err=1 for that cycle only.
  - Loading in DONE leaves the FSM in DONE.
- start while in RUN: ignored; no restart, count continues.
- en=0: no change to Cout or wrap_cnt. FSM transitions (start/stop) still occur.
- carry_out is asserted exactly in the cycle before the wrap edge, so a chained stage increments on the same edge that this stage wraps.
- Cout is never observed >= MOD except transiently through illegal parameters. If corrupted, the next enabled increment forces Cout to 0.
- clear asserted mid-count: outputs go to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/idle:
  - Stimulus: MOD=5; clear low, then high; en=1, no start for 10 cycles.
  - Required: Cout=0, running=0, wrap_cnt=0 throughout.
- Free-run wrap:
  - Stimulus: start pulse, then en=1 for 12 cycles, oneshot=0.
  - Required: Cout = 1,2,3,4,0,1,2,3,4,0,1,2; wrap_cnt=2; carry_out high in the cycles where Cout=4.
- One-shot:
  - Stimulus: oneshot=1, start, en=1 for 8 cycles.
  - Required: Cout reaches 4 then holds; done=1, running=0. A second start -> Cout=0, then counts 1,2.
- Load:
  - Load 3 while counting with en=1 -> next Cout=3 (no increment), then 4, 0.
  - Load 7 -> Cout=0 and load_err pulses exactly 1 cycle.
- Stop/enable gating:
  - Stimulus: stop at Cout=2, then en toggling for 5 cycles, then start.
  - Required: Cout stays 2 while stopped; after start, resumes 3,4,0. With en=0 and running, Cout holds.
- Async reset mid-count plus cascade:
  - Stimulus: two instances (MOD=5 feeding MOD=3) count 20 cycles; then clear pulses low between clock edges.
  - Required: before clear, low/high digits track a base-5 count, with the high digit wrapping at 3. On clear, both Cout and wrap_cnt go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/mod_n_up_counter_if.sv
// rtl/mod_n_up_counter_if.sv - control/status bundle for the modulo-N up counter
interface mod_n_up_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              en;
  logic              start;
  logic              stop;
  logic              oneshot;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  Cout;
  logic              running;
  logic              done;
  logic              tc;
  logic              carry_out;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              load_err;

  // Controller side: drives commands, observes count and status
  modport master (
    output en, start, stop, oneshot, load, load_val,
    input  Cout, running, done, tc, carry_out, wrap_cnt, load_err
  );

  // Counter side
  modport slave (
    input  en, start, stop, oneshot, load, load_val,
    output Cout, running, done, tc, carry_out, wrap_cnt, load_err
  );
endinterface

// File: rtl/mod_n_up_counter.sv
// rtl/mod_n_up_counter.sv - programmable modulo-N up counter with cascade carry
module mod_n_up_counter #(
  parameter int WIDTH  = 4,
  parameter int MOD    = 5,
  parameter int WRAP_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  mod_n_up_counter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // One extra bit so MOD == 2^WIDTH still compares correctly
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MOD - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cout_q, cout_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              load_err_q, load_err_d;

  logic load_ok;
  logic cout_bad;
  logic at_term;

  assign load_ok  = {1'b0, bus.load_val} < MOD_EXT;
  assign cout_bad = {1'b0, cout_q} >= MOD_EXT;
  assign at_term  = (cout_q == TERM);

  // State and count registers; clear takes effect without waiting for an edge
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cout_q     <= '0;
      wrap_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cout_q     <= cout_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Next state: load beats stop beats start beats counting
  always_comb begin
    state_d    = state_q;
    cout_d     = cout_q;
    wrap_d     = wrap_q;
    load_err_d = 1'b0;
    if (bus.load) begin
      // Out-of-range data is replaced by 0 and flagged; FSM state is kept
      cout_d     = load_ok ? bus.load_val : '0;
      load_err_d = ~load_ok;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.stop && bus.start) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (bus.en) begin
            if (cout_bad) begin
              cout_d = '0;
            end else if (at_term) begin
              if (bus.oneshot) begin
                state_d = S_DONE;
              end else begin
                cout_d = '0;
                if (wrap_q != '1) wrap_d = wrap_q + 1'b1;
              end
            end else begin
              cout_d = cout_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (bus.start) begin
            cout_d  = '0;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.Cout      = cout_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.tc        = at_term;
  // Raised in the cycle before the wrap edge so the next digit steps with it
  assign bus.carry_out = at_term & bus.en & (state_q == S_RUN);
  assign bus.wrap_cnt  = wrap_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_mod_n_up_counter.sv
// tb/tb_mod_n_up_counter.sv - scoreboard bench for a two-digit base-5/base-3 cascade
module tb_mod_n_up_counter;

  logic clk;
  logic clear;

  mod_n_up_counter_if #(.WIDTH(4), .WRAP_W(8)) if_lo ();
  mod_n_up_counter_if #(.WIDTH(4), .WRAP_W(8)) if_hi ();

  mod_n_up_counter #(.WIDTH(4), .MOD(5), .WRAP_W(8)) u_lo (
    .clk   (clk),
    .clear (clear),
    .bus   (if_lo)
  );

  mod_n_up_counter #(.WIDTH(4), .MOD(3), .WRAP_W(8)) u_hi (
    .clk   (clk),
    .clear (clear),
    .bus   (if_hi)
  );

  // High digit advances on the low digit's carry
  assign if_hi.en = if_lo.carry_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cout;
    logic       run;
    logic       done;
    logic [7:0] wrap;
    logic [3:0] hi;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Queue the expected post-edge state, advance one edge, then pop and compare
  task automatic step(input logic [3:0] c, input logic r, input logic d,
                      input logic [7:0] w, input logic [3:0] h);
    exp_t e;
    e.cout = c; e.run = r; e.done = d; e.wrap = w; e.hi = h;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("cout",    32'(if_lo.Cout),     32'(e.cout));
    chk("running", 32'(if_lo.running),  32'(e.run));
    chk("done",    32'(if_lo.done),     32'(e.done));
    chk("wrap",    32'(if_lo.wrap_cnt), 32'(e.wrap));
    chk("hi_cout", 32'(if_hi.Cout),     32'(e.hi));
  endtask

  initial begin
    clear = 1'b0;
    if_lo.en = 1'b0; if_lo.start = 1'b0; if_lo.stop = 1'b0;
    if_lo.oneshot = 1'b0; if_lo.load = 1'b0; if_lo.load_val = 4'd0;
    if_hi.start = 1'b0; if_hi.stop = 1'b0;
    if_hi.oneshot = 1'b0; if_hi.load = 1'b0; if_hi.load_val = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    chk("rst_cout",     32'(if_lo.Cout),     32'd0);
    chk("rst_running",  32'(if_lo.running),  32'd0);
    chk("rst_done",     32'(if_lo.done),     32'd0);
    chk("rst_wrap",     32'(if_lo.wrap_cnt), 32'd0);
    chk("rst_load_err", 32'(if_lo.load_err), 32'd0);

    // Idle with enable but no start: nothing moves
    if_lo.en = 1'b1;
    for (int i = 0; i < 10; i++) step(4'd0, 1'b0, 1'b0, 8'd0, 4'd0);

    // Free-running wrap
    if_lo.start = 1'b1;
    step(4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
    if_lo.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      chk("carry_out", 32'(if_lo.carry_out), 32'(((i - 1) % 5) == 4));
      step(4'((i % 5)), 1'b1, 1'b0, 8'((i / 5)), 4'd0);
    end

    // One-shot: start while running is ignored, then stop at terminal
    if_lo.oneshot = 1'b1;
    if_lo.start = 1'b1;
    step(4'd3, 1'b1, 1'b0, 8'd2, 4'd0);
    if_lo.start = 1'b0;
    step(4'd4, 1'b1, 1'b0, 8'd2, 4'd0);
    for (int i = 0; i < 6; i++) step(4'd4, 1'b0, 1'b1, 8'd2, 4'd0);
    chk("done_tc",    32'(if_lo.tc),        32'd1);
    chk("done_carry", 32'(if_lo.carry_out), 32'd0);
    if_lo.start = 1'b1;
    step(4'd0, 1'b1, 1'b0, 8'd2, 4'd0);
    if_lo.start = 1'b0;
    step(4'd1, 1'b1, 1'b0, 8'd2, 4'd0);
    step(4'd2, 1'b1, 1'b0, 8'd2, 4'd0);

    // Legal load suppresses the increment; illegal load forces 0 and flags
    if_lo.oneshot = 1'b0;
    if_lo.load = 1'b1; if_lo.load_val = 4'd3;
    step(4'd3, 1'b1, 1'b0, 8'd2, 4'd0);
    chk("load_err_legal", 32'(if_lo.load_err), 32'd0);
    if_lo.load = 1'b0;
    step(4'd4, 1'b1, 1'b0, 8'd2, 4'd0);
    step(4'd0, 1'b1, 1'b0, 8'd3, 4'd0);
    step(4'd1, 1'b1, 1'b0, 8'd3, 4'd0);
    if_lo.load = 1'b1; if_lo.load_val = 4'd7;
    step(4'd0, 1'b1, 1'b0, 8'd3, 4'd0);
    chk("load_err_pulse", 32'(if_lo.load_err), 32'd1);
    if_lo.load = 1'b0;
    step(4'd1, 1'b1, 1'b0, 8'd3, 4'd0);
    chk("load_err_clear", 32'(if_lo.load_err), 32'd0);

    // Stop holds the value regardless of enable; start resumes
    step(4'd2, 1'b1, 1'b0, 8'd3, 4'd0);
    if_lo.stop = 1'b1;
    step(4'd2, 1'b0, 1'b0, 8'd3, 4'd0);
    if_lo.stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_lo.en = 1'(i % 2);
      step(4'd2, 1'b0, 1'b0, 8'd3, 4'd0);
    end
    if_lo.en = 1'b1; if_lo.start = 1'b1;
    step(4'd2, 1'b1, 1'b0, 8'd3, 4'd0);
    if_lo.start = 1'b0;
    step(4'd3, 1'b1, 1'b0, 8'd3, 4'd0);
    step(4'd4, 1'b1, 1'b0, 8'd3, 4'd0);
    step(4'd0, 1'b1, 1'b0, 8'd4, 4'd0);
    if_lo.en = 1'b0;
    step(4'd0, 1'b1, 1'b0, 8'd4, 4'd0);
    step(4'd0, 1'b1, 1'b0, 8'd4, 4'd0);
    if_lo.en = 1'b1;

    // Load while DONE keeps the FSM in DONE
    if_lo.oneshot = 1'b1;
    for (int i = 1; i <= 4; i++) step(4'(i), 1'b1, 1'b0, 8'd4, 4'd0);
    step(4'd4, 1'b0, 1'b1, 8'd4, 4'd0);
    if_lo.load = 1'b1; if_lo.load_val = 4'd2;
    step(4'd2, 1'b0, 1'b1, 8'd4, 4'd0);
    if_lo.load = 1'b0;
    step(4'd2, 1'b0, 1'b1, 8'd4, 4'd0);
    if_lo.stop = 1'b1;
    step(4'd2, 1'b0, 0, 8'd4, 4'd0);
    if_lo.stop = 1'b0; if_lo.oneshot = 1'b0;

    // Cascade: fresh clear, start both digits, count 21 edges
    clear = 1'b0;
    #1;
    chk("clr_idle_cout", 32'(if_lo.Cout), 32'd0);
    clear = 1'b1;
    if_lo.start = 1'b1; if_hi.start = 1'b1;
    step(4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
    if_lo.start = 1'b0; if_hi.start = 1'b0;
    for (int n = 1; n <= 21; n++)
      step(4'((n % 5)), 1'b1, 1'b0, 8'((n / 5)), 4'(((n / 5) % 3)));
    chk("hi_wrap", 32'(if_hi.wrap_cnt), 32'd1);

    // Asynchronous clear between edges
    #2;
    clear = 1'b0;
    #1;
    chk("async_lo_cout",    32'(if_lo.Cout),     32'd0);
    chk("async_hi_cout",    32'(if_hi.Cout),     32'd0);
    chk("async_lo_wrap",    32'(if_lo.wrap_cnt), 32'd0);
    chk("async_hi_wrap",    32'(if_hi.wrap_cnt), 32'd0);
    chk("async_lo_running", 32'(if_lo.running),  32'd0);
    clear = 1'b1;
    step(4'd0, 1'b0, 1'b0, 8'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
